mem_stage: RTL and testbench

Memory-access stage of the five-stage LoongArch pipeline, between EXE and WB. Latches the EXE payload, waits for load data from the data SRAM port (request issued by EXE), and selects ALU result or load data as the writeback value. Holds returned load data in a one-entry buffer while WB stalls. Reports its destination and result to ID for hazard detection and forwarding.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_rdata_buf.sv | 44 ++++
 rtl/mem_stage.sv | 86 ++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - bus widths, field layouts and payload types shared by the MEM stage
`ifndef EXE_TO_MEM_BUS_WIDTH
`define EXE_TO_MEM_BUS_WIDTH 108
`endif
`ifndef MEM_TO_WB_BUS_WIDTH
`define MEM_TO_WB_BUS_WIDTH 70
`endif
`ifndef MEM_TO_ID_BUS_WIDTH
`define MEM_TO_ID_BUS_WIDTH 40
`endif

package mem_stage_pkg;

    localparam int EXE_TO_MEM_W = `EXE_TO_MEM_BUS_WIDTH;
    localparam int MEM_TO_WB_W  = `MEM_TO_WB_BUS_WIDTH;
    localparam int MEM_TO_ID_W  = `MEM_TO_ID_BUS_WIDTH;

    // Packed structs are declared MSB first so they overlay the flat buses directly.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rkd_value;
        logic [31:0] alu_result;
        logic        res_from_mem;
        logic        reg_we;
        logic        mem_en;
        logic [3:0]  mem_we;
        logic [4:0]  reg_waddr;
    } exe_to_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] final_result;
        logic        reg_we;
        logic [4:0]  reg_waddr;
    } mem_to_wb_t;

    typedef struct packed {
        logic        mem_valid;
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic [31:0] final_result;
        logic        data_pending;
    } mem_to_id_t;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - pipeline handshake, payload and data SRAM response signals around MEM
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                    exe_to_mem_valid;
    logic                    mem_allow_in;
    logic [EXE_TO_MEM_W-1:0] exe_to_mem_bus;
    logic                    mem_to_wb_valid;
    logic                    wb_allow_in;
    logic [MEM_TO_WB_W-1:0]  mem_to_wb_bus;
    logic [MEM_TO_ID_W-1:0]  mem_to_id_bus;
    logic                    data_sram_data_ok;
    logic [31:0]             data_sram_rdata;

    modport slave (
        input  exe_to_mem_valid, exe_to_mem_bus, wb_allow_in,
               data_sram_data_ok, data_sram_rdata,
        output mem_allow_in, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
    );

    modport master (
        output exe_to_mem_valid, exe_to_mem_bus, wb_allow_in,
               data_sram_data_ok, data_sram_rdata,
        input  mem_allow_in, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
    );

endinterface

// File: rtl/mem_rdata_buf.sv
// rtl/mem_rdata_buf.sv - one-entry load data buffer, data_ok qualification and writeback result mux
module mem_rdata_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_load,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    input  logic        wb_allow_in,
    input  logic        leave,
    input  logic [31:0] alu_result,
    output logic        buf_valid,
    output logic        data_ok_hon,
    output logic [31:0] final_result
);

    logic [31:0] buf_data;
    logic        buf_set;

    // Once the buffer holds data, further data_ok pulses cannot belong to this load.
    assign data_ok_hon = is_load && !buf_valid && data_ok;
    assign buf_set     = data_ok_hon && !wb_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_data  <= 32'd0;
        end else if (buf_set) begin
            buf_valid <= 1'b1;
            buf_data  <= rdata;
        end else if (leave) begin
            buf_valid <= 1'b0;
        end
    end

    always_comb begin
        final_result = alu_result;
        if (buf_valid) begin
            final_result = buf_data;
        end else if (is_load) begin
            final_result = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LoongArch MEM stage: payload latch, load completion, WB/ID buses (option: MEM_FWD_EN)
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave stage
);

    logic        mem_valid;
    exe_to_mem_t payload;
    logic        is_load;
    logic        ready_go;
    logic        mem_allow_in;
    logic        mem_to_wb_valid;
    logic        leave;
    logic        buf_valid;
    logic        data_ok_hon;
    logic [31:0] final_result;
    mem_to_wb_t  wb_bus;
    mem_to_id_t  id_bus;
    logic        unused_payload;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            payload   <= '0;
        end else if (mem_allow_in) begin
            mem_valid <= stage.exe_to_mem_valid;
            if (stage.exe_to_mem_valid) begin
                payload <= stage.exe_to_mem_bus;
            end
        end
    end

    assign is_load         = mem_valid && payload.res_from_mem;
    assign ready_go        = !is_load || buf_valid || data_ok_hon;
    assign mem_allow_in    = !mem_valid || (ready_go && stage.wb_allow_in);
    assign mem_to_wb_valid = mem_valid && ready_go;
    assign leave           = mem_to_wb_valid && stage.wb_allow_in;

    mem_rdata_buf u_rdata_buf (
        .clk          (clk),
        .reset        (reset),
        .is_load      (is_load),
        .data_ok      (stage.data_sram_data_ok),
        .rdata        (stage.data_sram_rdata),
        .wb_allow_in  (stage.wb_allow_in),
        .leave        (leave),
        .alu_result   (payload.alu_result),
        .buf_valid    (buf_valid),
        .data_ok_hon  (data_ok_hon),
        .final_result (final_result)
    );

    always_comb begin
        wb_bus              = '0;
        wb_bus.pc           = payload.pc;
        wb_bus.final_result = final_result;
        wb_bus.reg_we       = payload.reg_we;
        wb_bus.reg_waddr    = payload.reg_waddr;
    end

    always_comb begin
        id_bus           = '0;
        id_bus.mem_valid = mem_valid;
        id_bus.reg_we    = payload.reg_we;
        id_bus.reg_waddr = payload.reg_waddr;
`ifdef MEM_FWD_EN
        id_bus.final_result = final_result;
        id_bus.data_pending = is_load && !ready_go;
`else
        // Without forwarding, ID must stall on any write still sitting in MEM.
        id_bus.final_result = 32'd0;
        id_bus.data_pending = mem_valid && payload.reg_we;
`endif
    end

    assign stage.mem_allow_in    = mem_allow_in;
    assign stage.mem_to_wb_valid = mem_to_wb_valid;
    assign stage.mem_to_wb_bus   = wb_bus;
    assign stage.mem_to_id_bus   = id_bus;

    assign unused_payload = ^{payload.rkd_value, payload.mem_en, payload.mem_we};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed load/store/ALU vectors
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if sif ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .stage (sif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [69:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [107:0] mk_exe(input logic [31:0] pc, input logic [31:0] alu,
                                            input logic rfm, input logic we, input logic en,
                                            input logic [3:0] mwe, input logic [4:0] wa);
        return {pc, 32'hA5A5_0000 ^ pc, alu, rfm, we, en, mwe, wa};
    endfunction

    function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic [31:0] res,
                                          input logic we, input logic [4:0] wa);
        return {pc, res, we, wa};
    endfunction

    function automatic logic [39:0] id_exp(input logic v, input logic we, input logic [4:0] wa,
                                           input logic [31:0] res, input logic pend);
        logic unused_args;
        unused_args = ^{res, pend};
`ifdef MEM_FWD_EN
        return {v, we, wa, res, pend};
`else
        return {v, we, wa, 32'd0, v & we};
`endif
    endfunction

    // Monitor: every accepted WB transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && sif.mem_to_wb_valid && sif.wb_allow_in) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_unexpected: got %h expected no transfer", sif.mem_to_wb_bus);
            end else begin
                check("wb_bus", 128'(sif.mem_to_wb_bus), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        sif.exe_to_mem_valid  = 1'b0;
        sif.exe_to_mem_bus    = '0;
        sif.wb_allow_in       = 1'b1;
        sif.data_sram_data_ok = 1'b0;
        sif.data_sram_rdata   = 32'd0;
        repeat (2) tick();

        @(negedge clk);
        check("rst_wb_valid", 128'(sif.mem_to_wb_valid), 128'(1'b0));
        check("rst_allow_in", 128'(sif.mem_allow_in), 128'(1'b1));
        check("rst_wb_bus", 128'(sif.mem_to_wb_bus), 128'(70'd0));
        check("rst_id_bus", 128'(sif.mem_to_id_bus), 128'(40'd0));
        tick();
        reset = 1'b0;

        // ALU op passes through in one cycle
        sif.exe_to_mem_valid = 1'b1;
        sif.exe_to_mem_bus   = mk_exe(32'h1c00_0000, 32'h1234, 1'b0, 1'b1, 1'b0, 4'h0, 5'd5);
        exp_q.push_back(mk_wb(32'h1c00_0000, 32'h1234, 1'b1, 5'd5));
        tick();
        sif.exe_to_mem_valid = 1'b0;
        @(negedge clk);
        check("alu_id_bus", 128'(sif.mem_to_id_bus), 128'(id_exp(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0)));
        tick();

        // Load with data_ok in its first MEM cycle
        sif.exe_to_mem_valid = 1'b1;
        sif.exe_to_mem_bus   = mk_exe(32'h1c00_0004, 32'h8000, 1'b1, 1'b1, 1'b1, 4'h0, 5'd6);
        exp_q.push_back(mk_wb(32'h1c00_0004, 32'hDEAD_BEEF, 1'b1, 5'd6));
        tick();
        sif.exe_to_mem_valid  = 1'b0;
        sif.data_sram_data_ok = 1'b1;
        sif.data_sram_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        check("ld0_allow_in", 128'(sif.mem_allow_in), 128'(1'b1));
        tick();
        sif.data_sram_data_ok = 1'b0;
        sif.data_sram_rdata   = 32'd0;

        // Load whose data_ok arrives 3 cycles late
        sif.exe_to_mem_valid = 1'b1;
        sif.exe_to_mem_bus   = mk_exe(32'h1c00_0008, 32'h8004, 1'b1, 1'b1, 1'b1, 4'h0, 5'd7);
        exp_q.push_back(mk_wb(32'h1c00_0008, 32'h0BAD_F00D, 1'b1, 5'd7));
        tick();
        sif.exe_to_mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_wb_valid", 128'(sif.mem_to_wb_valid), 128'(1'b0));
            check("late_pending", 128'(sif.mem_to_id_bus[0]), 128'(1'b1));
            check("late_allow_in", 128'(sif.mem_allow_in), 128'(1'b0));
            tick();
        end
        sif.data_sram_data_ok = 1'b1;
        sif.data_sram_rdata   = 32'h0BAD_F00D;
        @(negedge clk);
        check("late_exit_allow", 128'(sif.mem_allow_in), 128'(1'b1));
        tick();
        sif.data_sram_data_ok = 1'b0;
        sif.data_sram_rdata   = 32'd0;

        // data_ok during a WB stall: buffered value must survive rdata changing
        sif.exe_to_mem_valid = 1'b1;
        sif.exe_to_mem_bus   = mk_exe(32'h1c00_000c, 32'h8008, 1'b1, 1'b1, 1'b1, 4'h0, 5'd8);
        exp_q.push_back(mk_wb(32'h1c00_000c, 32'hDEAD_BEEF, 1'b1, 5'd8));
        tick();
        sif.exe_to_mem_valid  = 1'b0;
        sif.data_sram_data_ok = 1'b1;
        sif.data_sram_rdata   = 32'hDEAD_BEEF;
        sif.wb_allow_in       = 1'b0;
        @(negedge clk);
        check("stall_wb_valid", 128'(sif.mem_to_wb_valid), 128'(1'b1));
        tick();
        sif.data_sram_data_ok = 1'b0;
        sif.data_sram_rdata   = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_buf_result", 128'(sif.mem_to_wb_bus[37:6]), 128'(32'hDEAD_BEEF));
            tick();
        end
        sif.wb_allow_in = 1'b1;
        @(negedge clk);
        check("stall_exit_allow", 128'(sif.mem_allow_in), 128'(1'b1));
        tick();
        @(negedge clk);
        check("stall_drained", 128'(sif.mem_to_wb_valid), 128'(1'b0));
        tick();

        // Reset with a buffered load, then a stray data_ok
        sif.exe_to_mem_valid = 1'b1;
        sif.exe_to_mem_bus   = mk_exe(32'h1c00_0010, 32'h800c, 1'b1, 1'b1, 1'b1, 4'h0, 5'd9);
        tick();
        sif.exe_to_mem_valid  = 1'b0;
        sif.data_sram_data_ok = 1'b1;
        sif.data_sram_rdata   = 32'h0000_0077;
        sif.wb_allow_in       = 1'b0;
        tick();
        sif.data_sram_data_ok = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sif.wb_allow_in       = 1'b1;
        sif.data_sram_data_ok = 1'b1;
        sif.data_sram_rdata   = 32'h0000_0099;
        @(negedge clk);
        check("rst_ld_wb_valid", 128'(sif.mem_to_wb_valid), 128'(1'b0));
        check("rst_ld_id_bus", 128'(sif.mem_to_id_bus), 128'(40'd0));
        tick();
        sif.data_sram_data_ok = 1'b0;
        sif.data_sram_rdata   = 32'd0;
        sif.exe_to_mem_valid  = 1'b1;
        sif.exe_to_mem_bus    = mk_exe(32'h1c00_0014, 32'h4242, 1'b0, 1'b1, 1'b0, 4'h0, 5'd9);
        exp_q.push_back(mk_wb(32'h1c00_0014, 32'h4242, 1'b1, 5'd9));
        tick();
        sif.exe_to_mem_valid = 1'b0;
        tick();

        // Store then ALU back to back; a stray data_ok on the ALU op is dropped
        sif.exe_to_mem_valid = 1'b1;
        sif.exe_to_mem_bus   = mk_exe(32'h1c00_0018, 32'h0100, 1'b0, 1'b0, 1'b1, 4'hf, 5'd0);
        exp_q.push_back(mk_wb(32'h1c00_0018, 32'h0100, 1'b0, 5'd0));
        tick();
        sif.exe_to_mem_bus = mk_exe(32'h1c00_001c, 32'h0005, 1'b0, 1'b1, 1'b0, 4'h0, 5'd10);
        exp_q.push_back(mk_wb(32'h1c00_001c, 32'h0005, 1'b1, 5'd10));
        @(negedge clk);
        check("st_allow_in", 128'(sif.mem_allow_in), 128'(1'b1));
        check("st_id_bus", 128'(sif.mem_to_id_bus), 128'(id_exp(1'b1, 1'b0, 5'd0, 32'h0100, 1'b0)));
        tick();
        sif.exe_to_mem_valid  = 1'b0;
        sif.data_sram_data_ok = 1'b1;
        sif.data_sram_rdata   = 32'hFFFF_FFFF;
        @(negedge clk);
        check("alu2_id_bus", 128'(sif.mem_to_id_bus), 128'(id_exp(1'b1, 1'b1, 5'd10, 32'h0005, 1'b0)));
        tick();
        sif.data_sram_data_ok = 1'b0;
        sif.data_sram_rdata   = 32'd0;

        // Back-to-back loads with data_ok held high
        sif.exe_to_mem_valid = 1'b1;
        sif.exe_to_mem_bus   = mk_exe(32'h1c00_0020, 32'h9000, 1'b1, 1'b1, 1'b1, 4'h0, 5'd11);
        exp_q.push_back(mk_wb(32'h1c00_0020, 32'h1111_1111, 1'b1, 5'd11));
        tick();
        sif.exe_to_mem_bus = mk_exe(32'h1c00_0024, 32'h9004, 1'b1, 1'b1, 1'b1, 4'h0, 5'd12);
        exp_q.push_back(mk_wb(32'h1c00_0024, 32'h2222_2222, 1'b1, 5'd12));
        sif.data_sram_data_ok = 1'b1;
        sif.data_sram_rdata   = 32'h1111_1111;
        @(negedge clk);
        check("b2b_allow_in", 128'(sif.mem_allow_in), 128'(1'b1));
        tick();
        sif.exe_to_mem_valid = 1'b0;
        sif.data_sram_rdata  = 32'h2222_2222;
        tick();
        sif.data_sram_data_ok = 1'b0;
        sif.data_sram_rdata   = 32'd0;
        tick();

        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
